// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline hazard controller: instruction field
// positions, opcode constants, FSM state encoding and the register-file
// read/write flag decode functions used by the stage flag decoders.
// Field naming: Ra = instr[13:11], Rb = instr[10:8].
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam int unsigned INSTR_W         = 16;
    localparam int unsigned MEM_TIMEOUT_DEF = 255;
    localparam int unsigned TMO_W_DEF       = 8;

    // Bubble encoding; its read/write flags always decode to 0.
    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

    // Opcode field positions
    localparam int unsigned OP1_HI = 15;
    localparam int unsigned OP1_LO = 14;
    localparam int unsigned OP2_HI = 13;
    localparam int unsigned OP2_LO = 11;
    localparam int unsigned OP3_HI = 7;
    localparam int unsigned OP3_LO = 4;

    // op1 groups
    localparam logic [1:0] OP1_LD  = 2'b00;
    localparam logic [1:0] OP1_ST  = 2'b01;
    localparam logic [1:0] OP1_BRG = 2'b10;
    localparam logic [1:0] OP1_ALU = 2'b11;

    // op2 within the branch group
    localparam logic [2:0] OP2_LI  = 3'b000;
    localparam logic [2:0] OP2_B   = 3'b100;
    localparam logic [2:0] OP2_BCC = 3'b111;

    // op3 within the ALU group
    localparam logic [3:0] OP3_ADD = 4'b0000;
    localparam logic [3:0] OP3_CMP = 4'b0101;
    localparam logic [3:0] OP3_MOV = 4'b0110;
    localparam logic [3:0] OP3_IN  = 4'b1100;
    localparam logic [3:0] OP3_OUT = 4'b1101;
    localparam logic [3:0] OP3_HLT = 4'b1111;

    // FSM state encoding
    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    function automatic logic [1:0] op1_of(input logic [INSTR_W-1:0] instr);
        return instr[OP1_HI:OP1_LO];
    endfunction

    function automatic logic [2:0] op2_of(input logic [INSTR_W-1:0] instr);
        return instr[OP2_HI:OP2_LO];
    endfunction

    function automatic logic [3:0] op3_of(input logic [INSTR_W-1:0] instr);
        return instr[OP3_HI:OP3_LO];
    endfunction

    function automatic logic is_hlt(input logic [INSTR_W-1:0] instr);
        return (op1_of(instr) == OP1_ALU) && (op3_of(instr) == OP3_HLT);
    endfunction

    function automatic logic is_branch(input logic [INSTR_W-1:0] instr);
        return (op1_of(instr) == OP1_BRG) &&
               ((op2_of(instr) == OP2_B) || (op2_of(instr) == OP2_BCC));
    endfunction

    // LD shares op1=00 with the NOP encoding, so the bubble is excluded.
    function automatic logic is_mem(input logic [INSTR_W-1:0] instr);
        return (instr != NOP_INSTR) &&
               ((op1_of(instr) == OP1_LD) || (op1_of(instr) == OP1_ST));
    endfunction

    // Register-file read flags {ra, rb}
    function automatic logic [1:0] instr_to_rf(input logic [INSTR_W-1:0] instr);
        logic [1:0] rf;
        rf = 2'b00;
        if (instr != NOP_INSTR) begin
            case (op1_of(instr))
                OP1_LD:  rf = 2'b01;           // base register
                OP1_ST:  rf = 2'b11;           // data + base
                OP1_ALU: begin
                    casez (op3_of(instr))
                        4'b00??, 4'b010?: rf = 2'b11; // ADD..XOR, CMP
                        OP3_MOV:          rf = 2'b10;
                        4'b10??:          rf = 2'b01; // shifts act on Rb
                        OP3_OUT:          rf = 2'b10;
                        default:          rf = 2'b00;
                    endcase
                end
                default: rf = 2'b00;           // LI / branches read nothing
            endcase
        end
        return rf;
    endfunction

    // Register-file write flags {wa, wb}
    function automatic logic [1:0] instr_to_wf(input logic [INSTR_W-1:0] instr);
        logic [1:0] wf;
        wf = 2'b00;
        if (instr != NOP_INSTR) begin
            case (op1_of(instr))
                OP1_LD:  wf = 2'b10;
                OP1_BRG: wf = (op2_of(instr) == OP2_LI) ? 2'b01 : 2'b00;
                OP1_ALU: begin
                    casez (op3_of(instr))
                        OP3_CMP:          wf = 2'b00;
                        4'b00??, 4'b0100: wf = 2'b01;
                        OP3_MOV:          wf = 2'b01;
                        4'b10??:          wf = 2'b01;
                        OP3_IN:           wf = 2'b01;
                        default:          wf = 2'b00;
                    endcase
                end
                default: wf = 2'b00;           // ST writes nothing
            endcase
        end
        return wf;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Groups fetch, data-memory, branch and stage-register signals of the hazard
// controller. master = controller, slave = fetch/memory/forwarding side.
//   fetch_valid/fetch_instr/fetch_ready : fetch handshake
//   br_taken, mem_ack, restart          : control inputs
//   mem_req, flush, stall, halted, mem_err : status outputs
//   instr0..2 + rarf0/rbrf0/rawf1/rbwf1/rawf2/rbwf2 : stage regs and flags
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if;
    import pipe_pkg::*;

    logic                fetch_valid;
    logic [INSTR_W-1:0]  fetch_instr;
    logic                fetch_ready;
    logic                br_taken;
    logic                mem_ack;
    logic                mem_req;
    logic                restart;
    logic [INSTR_W-1:0]  instr0;
    logic [INSTR_W-1:0]  instr1;
    logic [INSTR_W-1:0]  instr2;
    logic                rarf0;
    logic                rbrf0;
    logic                rawf1;
    logic                rbwf1;
    logic                rawf2;
    logic                rbwf2;
    logic                flush;
    logic                stall;
    logic                halted;
    logic                mem_err;

    modport master (
        input  fetch_valid, fetch_instr, br_taken, mem_ack, restart,
        output fetch_ready, mem_req, instr0, instr1, instr2,
               rarf0, rbrf0, rawf1, rbwf1, rawf2, rbwf2,
               flush, stall, halted, mem_err
    );

    modport slave (
        output fetch_valid, fetch_instr, br_taken, mem_ack, restart,
        input  fetch_ready, mem_req, instr0, instr1, instr2,
               rarf0, rbrf0, rawf1, rbwf1, rawf2, rbwf2,
               flush, stall, halted, mem_err
    );

endinterface

// File: rtl/pipe_flag_decode.sv
// ---------------------------------------------------------------------------
// pipe_flag_decode
// Register-file read/write flag decode for one stage register.
//   i_instr : stage instruction
//   o_rarf/o_rbrf : instruction reads Ra/Rb
//   o_rawf/o_rbwf : instruction writes Ra/Rb
// ---------------------------------------------------------------------------
module pipe_flag_decode
    import pipe_pkg::*;
(
    input  logic [INSTR_W-1:0] i_instr,
    output logic               o_rarf,
    output logic               o_rbrf,
    output logic               o_rawf,
    output logic               o_rbwf
);

    logic [1:0] w_rf;
    logic [1:0] w_wf;

    always_comb begin
        w_rf = instr_to_rf(i_instr);
        w_wf = instr_to_wf(i_instr);
    end

    assign o_rarf = w_rf[1];
    assign o_rbrf = w_rf[0];
    assign o_rawf = w_wf[1];
    assign o_rbwf = w_wf[0];

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Sequencing controller for the 3-deep in-flight window (instr0 decode,
// instr1 execute/memory, instr2 writeback): memory hold with bubbles and
// timeout, branch flush, and HLT drain/halt FSM.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pipe_hazard_ctrl_if.master (fetch, memory, branch, status,
//                stage registers and their register-file flags)
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int unsigned TMO_W       = TMO_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    pipe_hazard_ctrl_if.master bus
);

    logic [INSTR_W-1:0] r_instr0, r_instr1, r_instr2;
    logic [1:0]         r_state;
    logic [TMO_W-1:0]   r_wait_cnt;
    logic               r_mem_err;

    logic [INSTR_W-1:0] w_instr0_nxt, w_instr1_nxt, w_instr2_nxt;
    logic [1:0]         w_state_nxt;
    logic [TMO_W-1:0]   w_wait_cnt_nxt;
    logic               w_mem_err_nxt;

    logic w_mem_req, w_hold, w_timeout, w_flush, w_fetch_ready, w_accept;
    logic w_rarf0, w_rbrf0, w_rawf0, w_rbwf0;
    logic w_rarf1, w_rbrf1, w_rawf1, w_rbwf1;
    logic w_rarf2, w_rbrf2, w_rawf2, w_rbwf2;
    logic w_unused_flags;

    // Hazard conditions; a same-cycle ack means zero-wait, no hold.
    assign w_mem_req     = is_mem(r_instr1);
    assign w_hold        = w_mem_req & ~bus.mem_ack;
    assign w_timeout     = w_hold & (r_wait_cnt == TMO_W'(MEM_TIMEOUT));
    assign w_flush       = bus.br_taken & is_branch(r_instr1) & ~w_hold;
    // rst_n term keeps fetch_ready low while reset is asserted.
    assign w_fetch_ready = rst_n & (r_state == ST_RUN) & ~w_hold & ~w_flush;
    assign w_accept      = bus.fetch_valid & w_fetch_ready;

    // Next-state: timeout > hold > flush > HLT retire > normal advance
    always_comb begin
        w_state_nxt    = r_state;
        w_instr0_nxt   = r_instr0;
        w_instr1_nxt   = r_instr1;
        w_instr2_nxt   = r_instr2;
        w_wait_cnt_nxt = '0;
        w_mem_err_nxt  = r_mem_err;

        if (w_timeout) begin
            w_instr0_nxt  = NOP_INSTR;
            w_instr1_nxt  = NOP_INSTR;
            w_instr2_nxt  = NOP_INSTR;
            w_mem_err_nxt = 1'b1;
            w_state_nxt   = ST_HALTED;
        end else if (w_hold) begin
            w_instr2_nxt   = NOP_INSTR;
            w_wait_cnt_nxt = r_wait_cnt + TMO_W'(1);
        end else if (w_flush) begin
            w_instr2_nxt = r_instr1;
            w_instr1_nxt = NOP_INSTR;
            w_instr0_nxt = NOP_INSTR;
            // Squashing the HLT in decode cancels the drain.
            if ((r_state == ST_DRAIN) && is_hlt(r_instr0))
                w_state_nxt = ST_RUN;
        end else if ((r_state == ST_DRAIN) && is_hlt(r_instr2)) begin
            w_instr0_nxt = NOP_INSTR;
            w_instr1_nxt = NOP_INSTR;
            w_instr2_nxt = NOP_INSTR;
            w_state_nxt  = ST_HALTED;
        end else begin
            w_instr2_nxt = r_instr1;
            w_instr1_nxt = r_instr0;
            w_instr0_nxt = w_accept ? bus.fetch_instr : NOP_INSTR;
            case (r_state)
                ST_RUN: begin
                    if (w_accept && is_hlt(bus.fetch_instr))
                        w_state_nxt = ST_DRAIN;
                end
                ST_HALTED: begin
                    if (bus.restart)
                        w_state_nxt = ST_RUN;
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // State and pipe registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_instr0   <= NOP_INSTR;
            r_instr1   <= NOP_INSTR;
            r_instr2   <= NOP_INSTR;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_instr0   <= w_instr0_nxt;
            r_instr1   <= w_instr1_nxt;
            r_instr2   <= w_instr2_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_mem_err  <= w_mem_err_nxt;
        end
    end

    // Per-stage flag decode
    pipe_flag_decode u_dec0 (
        .i_instr (r_instr0),
        .o_rarf  (w_rarf0),
        .o_rbrf  (w_rbrf0),
        .o_rawf  (w_rawf0),
        .o_rbwf  (w_rbwf0)
    );

    pipe_flag_decode u_dec1 (
        .i_instr (r_instr1),
        .o_rarf  (w_rarf1),
        .o_rbrf  (w_rbrf1),
        .o_rawf  (w_rawf1),
        .o_rbwf  (w_rbwf1)
    );

    pipe_flag_decode u_dec2 (
        .i_instr (r_instr2),
        .o_rarf  (w_rarf2),
        .o_rbrf  (w_rbrf2),
        .o_rawf  (w_rawf2),
        .o_rbwf  (w_rbwf2)
    );

    // Forwarding only needs reads in decode and writes downstream.
    assign w_unused_flags = ^{w_rawf0, w_rbwf0, w_rarf1, w_rbrf1, w_rarf2, w_rbrf2};

    assign bus.fetch_ready = w_fetch_ready;
    assign bus.mem_req     = w_mem_req;
    assign bus.instr0      = r_instr0;
    assign bus.instr1      = r_instr1;
    assign bus.instr2      = r_instr2;
    assign bus.rarf0       = w_rarf0;
    assign bus.rbrf0       = w_rbrf0;
    assign bus.rawf1       = w_rawf1;
    assign bus.rbwf1       = w_rbwf1;
    assign bus.rawf2       = w_rawf2;
    assign bus.rbwf2       = w_rbwf2;
    assign bus.flush       = w_flush;
    assign bus.stall       = w_hold;
    assign bus.halted      = (r_state == ST_HALTED);
    assign bus.mem_err     = r_mem_err;

endmodule
